assoc_plb_cache: RTL

//  N-way set-associative successor to the direct-mapped PLB cache; drop-in for the frontend PosMap lookaside buffer.

---
 rtl/assoc_plb_cache_pkg.sv | 23 ++
 rtl/assoc_plb_tag_array.sv | 100 ++++++++++
 rtl/assoc_plb_cache.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_plb_cache_pkg.sv
// Shared definitions for the set-associative PLB cache: command encodings,
// FSM states and a width helper for degenerate (size 1) dimensions.
package assoc_plb_cache_pkg;

    typedef enum logic [1:0] {
        CACHE_WRITE       = 2'd0,
        CACHE_READ        = 2'd1,
        CACHE_INIT_REFILL = 2'd2,
        CACHE_REFILL      = 2'd3
    } cache_cmd_e;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_REFILL = 2'd2
    } state_e;

    // Index width for n entries; a single entry still needs a 1-bit signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/assoc_plb_tag_array.sv
// Tag/valid/dirty/LRU-age storage for every set; performs hit detection and
// victim selection (matching way, else lowest invalid way, else LRU way).
module assoc_plb_tag_array
    import assoc_plb_cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int TAG_W = 23,
    localparam int SET_W = idx_width(SETS),
    localparam int WAY_W = idx_width(WAYS)
) (
    input  logic             clk,
    input  logic [SET_W-1:0] set_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             clear_i,
    input  logic             touch_i,
    input  logic [WAY_W-1:0] way_i,
    input  logic             dirty_i,
    input  logic             fill_i,
    output logic             hit_o,
    output logic [WAY_W-1:0] hit_way_o,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             victim_valid_o,
    output logic             victim_dirty_o,
    output logic [TAG_W-1:0] victim_tag_o
);

    // Age 0 is MRU, WAYS-1 is LRU; ages within a set are always a permutation.
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic             valid_q [SETS][WAYS];
    logic             dirty_q [SETS][WAYS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];

    logic             hit;
    logic             inv_found;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set_i][w] && tag_q[set_i][w] == tag_i) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_i][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[set_i][w] == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        victim = hit ? hit_way : (inv_found ? inv_way : lru_way);
    end

    assign hit_o          = hit;
    assign hit_way_o      = hit_way;
    assign victim_way_o   = victim;
    assign victim_valid_o = valid_q[set_i][victim];
    assign victim_dirty_o = dirty_q[set_i][victim];
    assign victim_tag_o   = tag_q[set_i][victim];

    // NOTE: the arrays carry no reset; the INIT sweep clears valid/dirty/age one set per cycle.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[set_i][w] <= 1'b0;
                dirty_q[set_i][w] <= 1'b0;
                age_q[set_i][w]   <= WAY_W'(w);
            end
        end else begin
            if (fill_i) begin
                tag_q[set_i][way_i]   <= tag_i;
                valid_q[set_i][way_i] <= 1'b1;
                dirty_q[set_i][way_i] <= 1'b0;
            end
            if (dirty_i) begin
                dirty_q[set_i][way_i] <= 1'b1;
            end
            if (touch_i) begin
                for (int v = 0; v < WAYS; v++) begin
                    if (WAY_W'(v) == way_i) begin
                        age_q[set_i][v] <= '0;
                    end else if (age_q[set_i][v] < age_q[set_i][way_i]) begin
                        age_q[set_i][v] <= age_q[set_i][v] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/assoc_plb_cache.sv
// N-way set-associative PosMap lookaside cache with LRU refill and dirty-victim streaming.
// Optional performance counters are enabled by defining PLB_PERF_CNT_EN.
module assoc_plb_cache
    import assoc_plb_cache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int LOG_LINE_SIZE = 3,
    parameter int CAPACITY      = 1024,
    parameter int WAYS          = 2,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [1:0]            cmd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  hit_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  ready_o,
    output logic                  evict_valid_o,
    output logic [ADDR_WIDTH-1:0] evict_addr_o
`ifdef PLB_PERF_CNT_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o,
    output logic [31:0]           evict_count_o
`endif
);

    localparam int WORDS    = 1 << LOG_LINE_SIZE;
    localparam int LINES    = CAPACITY >> LOG_LINE_SIZE;
    localparam int SETS     = LINES / WAYS;
    localparam int SET_BITS = $clog2(SETS);
    localparam int SET_W    = idx_width(SETS);
    localparam int WAY_W    = idx_width(WAYS);
    localparam int OFF_W    = idx_width(WORDS);
    localparam int TAG_W    = ADDR_WIDTH - LOG_LINE_SIZE - SET_BITS;
    localparam int MIDX_W   = idx_width(CAPACITY);

    state_e                  state_q, state_d;
    logic [SET_W-1:0]        init_set_q, init_set_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [SET_W-1:0]        rf_set_q, rf_set_d;
    logic [WAY_W-1:0]        rf_way_q, rf_way_d;
    logic [TAG_W-1:0]        rf_tag_q, rf_tag_d;
    logic                    rf_evict_q, rf_evict_d;
    logic                    hit_q, hit_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    evict_valid_q, evict_valid_d;
    logic [ADDR_WIDTH-1:0]   evict_addr_q, evict_addr_d;

    logic [SET_W-1:0]        addr_set;
    logic [TAG_W-1:0]        addr_tag;
    logic [OFF_W-1:0]        addr_off;
    logic                    accept;
    logic                    victim_evict;

    logic [SET_W-1:0]        ta_set;
    logic                    ta_clear, ta_touch, ta_dirty, ta_fill;
    logic [WAY_W-1:0]        ta_way;
    logic                    lk_hit;
    logic [WAY_W-1:0]        lk_hit_way, lk_victim_way;
    logic                    lk_victim_valid, lk_victim_dirty;
    logic [TAG_W-1:0]        lk_victim_tag;

    logic [DATA_WIDTH-1:0]   data_q [CAPACITY];
    logic [MIDX_W-1:0]       mem_idx;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_we;

    function automatic logic [MIDX_W-1:0] mem_index(input logic [WAY_W-1:0] w,
                                                    input logic [SET_W-1:0] s,
                                                    input logic [OFF_W-1:0] o);
        return MIDX_W'((int'(w) * SETS + int'(s)) * WORDS + int'(o));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [TAG_W-1:0] t,
                                                        input logic [SET_W-1:0] s,
                                                        input logic [OFF_W-1:0] o);
        return (ADDR_WIDTH'(t) << (LOG_LINE_SIZE + SET_BITS))
             | (ADDR_WIDTH'(s) << LOG_LINE_SIZE)
             | ADDR_WIDTH'(o);
    endfunction

    assign addr_set = SET_W'((addr_i >> LOG_LINE_SIZE) & ADDR_WIDTH'(SETS - 1));
    assign addr_tag = TAG_W'(addr_i >> (LOG_LINE_SIZE + SET_BITS));
    assign addr_off = OFF_W'(addr_i);
    assign ready_o  = (state_q != S_INIT);
    assign accept   = enable_i & ready_o;
    assign ta_set   = (state_q == S_INIT) ? init_set_q : addr_set;

    // A victim is only written back when it holds data for a different line.
    assign victim_evict = lk_victim_valid & lk_victim_dirty & (lk_victim_tag != addr_tag);

    // Read and write share one index, so a refill reads the old word k as it writes the new one.
    always_comb begin
        if (state_q == S_REFILL) begin
            mem_idx = mem_index(rf_way_q, rf_set_q, off_q);
        end else if (cmd_i == CACHE_INIT_REFILL) begin
            mem_idx = mem_index(lk_victim_way, addr_set, '0);
        end else begin
            mem_idx = mem_index(lk_hit_way, addr_set, addr_off);
        end
    end

    assign mem_rdata = data_q[mem_idx];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_q[mem_idx] <= din_i;
        end
    end

    assoc_plb_tag_array #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk            (clk),
        .set_i          (ta_set),
        .tag_i          (addr_tag),
        .clear_i        (ta_clear),
        .touch_i        (ta_touch),
        .way_i          (ta_way),
        .dirty_i        (ta_dirty),
        .fill_i         (ta_fill),
        .hit_o          (lk_hit),
        .hit_way_o      (lk_hit_way),
        .victim_way_o   (lk_victim_way),
        .victim_valid_o (lk_victim_valid),
        .victim_dirty_o (lk_victim_dirty),
        .victim_tag_o   (lk_victim_tag)
    );

    always_comb begin
        state_d       = state_q;
        init_set_d    = init_set_q;
        off_d         = off_q;
        rf_set_d      = rf_set_q;
        rf_way_d      = rf_way_q;
        rf_tag_d      = rf_tag_q;
        rf_evict_d    = rf_evict_q;
        hit_d         = hit_q;
        dout_d        = dout_q;
        evict_valid_d = 1'b0;
        evict_addr_d  = evict_addr_q;
        ta_clear      = 1'b0;
        ta_touch      = 1'b0;
        ta_dirty      = 1'b0;
        ta_fill       = 1'b0;
        ta_way        = lk_hit_way;
        mem_we        = 1'b0;

        case (state_q)
            S_INIT: begin
                ta_clear   = 1'b1;
                init_set_d = init_set_q + 1'b1;
                if (init_set_q == SET_W'(SETS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    case (cache_cmd_e'(cmd_i))
                        CACHE_READ: begin
                            hit_d    = lk_hit;
                            ta_touch = lk_hit;
                            if (lk_hit) begin
                                dout_d = mem_rdata;
                            end
                        end
                        CACHE_WRITE: begin
                            hit_d    = lk_hit;
                            ta_touch = lk_hit;
                            ta_dirty = lk_hit;
                            mem_we   = lk_hit;
                        end
                        CACHE_INIT_REFILL: begin
                            hit_d      = 1'b0;
                            ta_way     = lk_victim_way;
                            ta_fill    = 1'b1;
                            ta_touch   = 1'b1;
                            mem_we     = 1'b1;
                            rf_set_d   = addr_set;
                            rf_way_d   = lk_victim_way;
                            rf_tag_d   = lk_victim_tag;
                            rf_evict_d = victim_evict;
                            off_d      = OFF_W'(1);
                            state_d    = (WORDS > 1) ? S_REFILL : S_IDLE;
                            if (victim_evict) begin
                                evict_valid_d = 1'b1;
                                dout_d        = mem_rdata;
                                evict_addr_d  = word_addr(lk_victim_tag, addr_set, '0);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_REFILL: begin
                if (accept && cmd_i == CACHE_REFILL) begin
                    mem_we = 1'b1;
                    off_d  = off_q + 1'b1;
                    if (rf_evict_q) begin
                        evict_valid_d = 1'b1;
                        dout_d        = mem_rdata;
                        evict_addr_d  = word_addr(rf_tag_q, rf_set_q, off_q);
                    end
                    if (off_q == OFF_W'(WORDS - 1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            init_set_q    <= '0;
            off_q         <= '0;
            rf_set_q      <= '0;
            rf_way_q      <= '0;
            rf_tag_q      <= '0;
            rf_evict_q    <= 1'b0;
            hit_q         <= 1'b0;
            dout_q        <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            init_set_q    <= init_set_d;
            off_q         <= off_d;
            rf_set_q      <= rf_set_d;
            rf_way_q      <= rf_way_d;
            rf_tag_q      <= rf_tag_d;
            rf_evict_q    <= rf_evict_d;
            hit_q         <= hit_d;
            dout_q        <= dout_d;
            evict_valid_q <= evict_valid_d;
            evict_addr_q  <= evict_addr_d;
        end
    end

    assign hit_o         = hit_q;
    assign dout_o        = dout_q;
    assign evict_valid_o = evict_valid_q;
    assign evict_addr_o  = evict_addr_q;

`ifdef PLB_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, evict_cnt_q;
    logic        rw_acc, hit_inc, miss_inc, evict_inc;

    assign rw_acc    = (state_q == S_IDLE) & accept & (cmd_i == CACHE_READ || cmd_i == CACHE_WRITE);
    assign hit_inc   = rw_acc & lk_hit;
    assign miss_inc  = rw_acc & ~lk_hit;
    assign evict_inc = (state_q == S_IDLE) & accept & (cmd_i == CACHE_INIT_REFILL) & victim_evict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            evict_cnt_q <= '0;
        end else begin
            if (hit_inc && hit_cnt_q != '1)     hit_cnt_q   <= hit_cnt_q + 1'b1;
            if (miss_inc && miss_cnt_q != '1)   miss_cnt_q  <= miss_cnt_q + 1'b1;
            if (evict_inc && evict_cnt_q != '1) evict_cnt_q <= evict_cnt_q + 1'b1;
        end
    end

    assign hit_count_o   = hit_cnt_q;
    assign miss_count_o  = miss_cnt_q;
    assign evict_count_o = evict_cnt_q;
`endif

endmodule
